// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM states and parity-mode constants for the parity serial link
// Purpose: types and constants common to the parity receiver and the parity transmitter.
// Ports: none (package).
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - running XOR accumulator with clear and enable
// Purpose: accumulates the XOR of the bits presented while en=1.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  synchronous active-low reset, clears acc
//   clr   in  clear acc to 0 (wins over en)
//   en    in  fold din into acc
//   din   in  bit to accumulate
//   acc   out running XOR
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/parity_serial_rx.sv
// rtl/parity_serial_rx.sv - parity-framed serial receiver with one-entry valid/ready output buffer
// Purpose: deserializes start, DATA_W data bits (LSB first), parity and stop bits sampled on
// bit_en strobes, checks parity and stop bit, and holds the word with its error flags.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   bit_en  in   bit strobe, sdi sampled only when 1
//   sdi     in   serial data, idle high
//   data    out  received word, valid while valid=1
//   par_err out  parity mismatch for data
//   frm_err out  stop bit was 0 for data
//   valid   out  output buffer occupied
//   ready   in   consumer accepts when valid && ready
//   ovr     out  one-cycle pulse: completed frame dropped because buffer was full
module parity_serial_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sdi,
  output logic [DATA_W-1:0] data,
  output logic              par_err,
  output logic              frm_err,
  output logic              valid,
  input  logic              ready,
  output logic              ovr
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic                acc_clr;
  logic                acc_en;
  logic                acc;
  logic                complete;

  parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (sdi),
    .acc   (acc)
  );

  // Frame FSM: only strobed cycles advance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    complete = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!sdi) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shift_d[i] = sdi;
            end
          end
          acc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          acc_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          complete = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output buffer: a completion may load in the same edge the old word is taken.
  always_comb begin
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || ready) begin
        data_d    = shift_q;
        par_err_d = (acc != ODD);
        frm_err_d = !sdi;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data    = data_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign valid   = valid_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_parity_serial_rx.sv
// tb/tb_parity_serial_rx.sv - self-checking bench for parity_serial_rx (odd and even instances)
module tb_parity_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       sdi = 1'b1;
  logic       ready = 1'b0;

  logic [7:0] data_o, data_e;
  logic       par_o, par_e, frm_o, frm_e, valid_o, valid_e, ovr_o, ovr_e;

  // Driver-side frame knowledge used by the model.
  logic       stop_now = 1'b0;
  logic [7:0] fr_data = 8'h00;
  logic       fr_par = 1'b0;
  logic       fr_stop = 1'b1;

  // Model of the output buffer.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_pe_o = 1'b0;
  logic       m_pe_e = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;

  logic       mon_on = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  parity_serial_rx #(.DATA_W(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
    .data(data_o), .par_err(par_o), .frm_err(frm_o),
    .valid(valid_o), .ready(ready), .ovr(ovr_o)
  );

  parity_serial_rx #(.DATA_W(8), .ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
    .data(data_e), .par_err(par_e), .frm_err(frm_e),
    .valid(valid_e), .ready(ready), .ovr(ovr_e)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A word is delivered when its stop strobe arrives; it goes into the buffer if the
  // buffer is empty or is being emptied this edge, otherwise it is lost with an ovr pulse.
  always @(posedge clk) begin : model
    logic occupied;
    int   ones;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_pe_o  <= 1'b0;
      m_pe_e  <= 1'b0;
      m_fe    <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      occupied = m_valid && !ready;
      m_ovr <= 1'b0;
      if (m_valid && ready) m_valid <= 1'b0;
      if (bit_en && stop_now) begin
        if (occupied) begin
          m_ovr <= 1'b1;
        end else begin
          ones = $countones(fr_data) + int'(fr_par);
          m_valid <= 1'b1;
          m_data  <= fr_data;
          m_pe_o  <= (ones % 2) != 1;
          m_pe_e  <= (ones % 2) != 0;
          m_fe    <= !fr_stop;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("valid_odd", {31'd0, valid_o}, {31'd0, m_valid});
      chk("valid_even", {31'd0, valid_e}, {31'd0, m_valid});
      chk("ovr_odd", {31'd0, ovr_o}, {31'd0, m_ovr});
      chk("ovr_even", {31'd0, ovr_e}, {31'd0, m_ovr});
      if (m_valid) begin
        chk("data_odd", {24'd0, data_o}, {24'd0, m_data});
        chk("data_even", {24'd0, data_e}, {24'd0, m_data});
        chk("par_odd", {31'd0, par_o}, {31'd0, m_pe_o});
        chk("par_even", {31'd0, par_e}, {31'd0, m_pe_e});
        chk("frm_odd", {31'd0, frm_o}, {31'd0, m_fe});
        chk("frm_even", {31'd0, frm_e}, {31'd0, m_fe});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame (11 = full frame), one strobe every gap cycles.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap, input int nbits, input logic rdy_at_stop);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      sdi      = bits[i];
      bit_en   = 1'b1;
      stop_now = (i == 10);
      fr_data  = d;
      fr_par   = p;
      fr_stop  = s;
      if (i == 10 && rdy_at_stop) ready = 1'b1;
      tick();
      bit_en   = 1'b0;
      stop_now = 1'b0;
      sdi      = 1'b1;
      if (i == 10 && rdy_at_stop) ready = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  task automatic expect_word(input string name, input logic [7:0] d, input logic pe_odd,
                             input logic pe_even, input logic fe);
    chk({name, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({name, "_data"}, {24'd0, data_o}, {24'd0, d});
    chk({name, "_par_odd"}, {31'd0, par_o}, {31'd0, pe_odd});
    chk({name, "_par_even"}, {31'd0, par_e}, {31'd0, pe_even});
    chk({name, "_frm"}, {31'd0, frm_o}, {31'd0, fe});
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("consume_valid", {31'd0, valid_o}, 32'd0);
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({name, "_data"}, {24'd0, data_o}, 32'd0);
    chk({name, "_par"}, {31'd0, par_o}, 32'd0);
    chk({name, "_frm"}, {31'd0, frm_o}, 32'd0);
    chk({name, "_ovr"}, {31'd0, ovr_o}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    mon_on = 1'b1;
    check_cleared("reset");
    rst_n = 1'b1;
    tick();

    // Clean odd frame; for the even instance the same parity bit is an error.
    send_frame(8'hA5, 1'b1, 1'b1, 1, 11, 1'b0);
    expect_word("clean", 8'hA5, 1'b0, 1'b1, 1'b0);
    consume();

    // Parity bit 0: odd reports error, even is clean.
    send_frame(8'hA5, 1'b0, 1'b1, 1, 11, 1'b0);
    expect_word("parerr", 8'hA5, 1'b1, 1'b0, 1'b0);
    consume();

    // Framing error, then a good frame.
    send_frame(8'h3C, 1'b1, 1'b0, 1, 11, 1'b0);
    expect_word("frmerr", 8'h3C, 1'b0, 1'b1, 1'b1);
    consume();
    tick();
    send_frame(8'h01, 1'b0, 1'b1, 1, 11, 1'b0);
    expect_word("after_frm", 8'h01, 1'b0, 1'b1, 1'b0);
    consume();

    // Backpressure: second back-to-back frame is dropped.
    send_frame(8'h11, 1'b1, 1'b1, 1, 11, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1, 11, 1'b0);
    chk("bp_ovr", {31'd0, ovr_o}, 32'd1);
    chk("bp_data", {24'd0, data_o}, 32'h11);
    tick();
    chk("bp_ovr_pulse", {31'd0, ovr_o}, 32'd0);
    consume();

    // Simultaneous accept and load.
    send_frame(8'h11, 1'b1, 1'b1, 1, 11, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1, 11, 1'b1);
    chk("sim_ovr", {31'd0, ovr_o}, 32'd0);
    expect_word("sim", 8'h22, 1'b0, 1'b1, 1'b0);
    consume();

    // Sparse strobes.
    send_frame(8'h5A, 1'b1, 1'b1, 4, 11, 1'b0);
    expect_word("sparse", 8'h5A, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame with a word held, then a full frame.
    send_frame(8'h5A, 1'b1, 1'b1, 1, 5, 1'b0);
    rst_n = 1'b0;
    tick();
    check_cleared("midreset");
    rst_n = 1'b1;
    tick();
    send_frame(8'h5A, 1'b1, 1'b1, 1, 11, 1'b0);
    expect_word("post_reset", 8'h5A, 1'b0, 1'b1, 1'b0);
    consume();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_serial_rx.md
# parity_serial_rx

Serial frame receiver with parity check: deserializes a start bit, DATA_W data bits (LSB first), one parity bit and one stop bit from a single-wire input sampled on bit strobes. It checks odd or even parity and the stop bit, then presents the word on a one-entry valid/ready output buffer. It is the receiving end of the parity-framed serial link whose transmit side is our parity generator, and it feeds downstream word consumers.

## Interface
- DATA_W, 8, number of data bits per frame (1..32)
- ODD, 1, parity mode: 1 = odd parity (data bits plus parity bit XOR to 1), 0 = even (XOR to 0)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- bit_en  in  1  bit strobe; sdi is sampled only in cycles with bit_en=1
- sdi  in  1  serial data in, idle high
- data  out  DATA_W  received word, valid while valid=1
- par_err  out  1  parity mismatch for the word in data, qualified by valid
- frm_err  out  1  stop bit was 0 for the word in data, qualified by valid
- valid  out  1  output buffer holds a word
- ready  in  1  consumer accepts; transfer when valid && ready
- ovr  out  1  one-cycle pulse: a completed frame was discarded because the buffer was full

## Operation
- Reset (rst_n=0 at a rising edge): state IDLE; data=0, par_err=0, frm_err=0, valid=0, ovr=0; bit counter and parity accumulator cleared. This reset aborts any partial frame.
- Only cycles with bit_en=1 advance the FSM. In other cycles, state, shift register and accumulator hold.
- FSM:
  - IDLE: bit_en && sdi==0 → DATA, clear counter and accumulator. bit_en && sdi==1 → stay.
  - DATA: shift sdi into bit (count) LSB-first, acc ^= sdi, count++. After DATA_W bits → PARITY.
  - PARITY: acc ^= sdi → STOP.
  - STOP: frame completes on this strobe → IDLE. Stop bit is not checked for start detection. A 0 stop bit only sets frm_err, and the next start needs a fresh bit_en with sdi==0.
- Parity error rule: par_err = (acc_final != ODD), where acc_final = XOR of the data bits and the parity bit.
- Frame completion (STOP strobe):
  - If the buffer is free, or is being freed this cycle (valid && ready), load data, par_err and frm_err, and set valid=1.
  - Otherwise discard the frame, pulse ovr=1 for one cycle, and leave the buffer unchanged.
- Output handshake: valid rises only on load. It falls the cycle after valid && ready unless a load occurs in that same cycle. data, par_err and frm_err stay stable while valid=1 and !ready.
- Errored frames are still delivered; flags travel with the word.

## Timing
- Latency: valid=1 in the cycle after the rising edge that sampled the stop bit (one register stage).
- Frame length: DATA_W+3 bit strobes (start, data, parity, stop). Back-to-back frames are allowed: a start can be taken on the strobe right after STOP.
- Simultaneous ready and completion: the consumer takes the old word and the new word loads in the same edge. valid stays 1 with no bubble and ovr=0.
- ovr is registered and asserts in the same cycle valid would have loaded.
- bit_en may be held high continuously, giving one bit per clock.
- rst_n low mid-frame or with valid=1 clears everything on that edge. No word is delivered.

## Structure
- Package parity_pkg: FSM state enum (IDLE, DATA, PARITY, STOP) and constants PAR_ODD=1'b1 and PAR_EVEN=1'b0, shared with the serial transmitter.
- Sub-module parity_acc: running XOR with clear and enable, output acc. It is reused by the transmitter to generate the parity bit.
- Bit counter width: $clog2(DATA_W+1).

## Test plan
- Clean odd frame, DATA_W=8, ODD=1, bit_en always 1: start 0, data 0xA5 (LSB first), parity 1, stop 1 → one cycle after the stop bit, valid=1, data=0xA5, par_err=0, frm_err=0.
- Parity error: same frame with parity bit 0 → data=0xA5, par_err=1, frm_err=0. With ODD=0, a parity bit of 0 gives par_err=0.
- Framing error: data 0x3C, correct parity, stop bit 0 → frm_err=1. The FSM returns to IDLE and the next valid frame 0x01 is received correctly.
- Backpressure: ready=0, two frames 0x11 then 0x22 → data stays 0x11, ovr pulses once at the second completion. Then ready=1 → valid drops and 0x22 is lost.
- Simultaneous accept and load: ready pulsed high exactly on the completion edge of frame 0x22 while 0x11 is held → 0x11 is transferred, then data=0x22, valid stays 1, ovr=0.
- Sparse strobes and reset: bit_en every 4th cycle, frame 0x5A → the same result as the continuous case. Asserting rst_n=0 after 4 data bits → all outputs 0, and a subsequent full frame 0x5A is received correctly.
